// File: rtl/ram_word_responder.sv
// rtl/ram_word_responder.sv - delayed DMA word responder backed by a host-loaded RAM; optional RAM_RESPONDER_STATS_EN adds read_count
module ram_word_responder #(
    parameter int                 RAM_WID        = 32,
    parameter int                 RAM_WORD_WID   = 16,
    parameter int                 RAM_WORD_INCR  = 2,
    parameter logic [RAM_WID-1:0] RAM_REAL_START = '0,
    parameter int                 WORD_CNT_WID   = 12,
    parameter int                 DELAY_CNTR_LEN = 8,
    parameter int                 DELAY_TOTAL    = 12
) (
    input  logic                    clk,
    input  logic                    rst_L,
    input  logic [RAM_WID-1:0]      ram_dma_addr,
    input  logic                    ram_read,
    output logic                    ram_valid,
    output logic [RAM_WORD_WID-1:0] ram_word,
    input  logic                    wr_en,
    input  logic [WORD_CNT_WID-1:0] wr_addr,
    input  logic [RAM_WORD_WID-1:0] wr_data,
    output logic                    busy,
    output logic                    addr_err,
    input  logic                    err_clr
`ifdef RAM_RESPONDER_STATS_EN
    ,
    output logic [31:0]             read_count
`endif
);

    localparam int DEPTH    = 1 << WORD_CNT_WID;
    localparam int ALIGN_SH = (RAM_WORD_INCR == 4) ? 2 : ((RAM_WORD_INCR == 2) ? 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_VALID, S_RELEASE} state_t;

    state_t                    r_state;
    logic [RAM_WORD_WID-1:0]   r_mem [0:DEPTH-1];
    logic [WORD_CNT_WID-1:0]   r_idx;
    logic                      r_bad;
    logic [DELAY_CNTR_LEN-1:0] r_cnt;
    logic                      r_valid;
    logic [RAM_WORD_WID-1:0]   r_word;
    logic                      r_busy;
    logic                      r_err;
`ifdef RAM_RESPONDER_STATS_EN
    logic [31:0]               r_read_count;
`endif

    logic [RAM_WID-1:0]        w_off;
    logic [RAM_WID-1:0]        w_idx_full;
    logic                      w_misalign;
    logic                      w_oor;

    // Unsigned wrap makes addresses below the start land far out of range.
    assign w_off      = ram_dma_addr - RAM_REAL_START;
    assign w_idx_full = w_off >> ALIGN_SH;
    assign w_misalign = (w_off & RAM_WID'(RAM_WORD_INCR - 1)) != '0;
    assign w_oor      = (w_idx_full >> WORD_CNT_WID) != '0;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_L) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_bad   <= 1'b0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_word  <= '0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
`ifdef RAM_RESPONDER_STATS_EN
            r_read_count <= '0;
`endif
        end else begin
            // Clear first so a same-cycle error set below takes priority.
            if (err_clr) begin
                r_err <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (ram_read) begin
                        r_idx   <= w_idx_full[WORD_CNT_WID-1:0];
                        r_bad   <= w_misalign | w_oor;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == DELAY_CNTR_LEN'(DELAY_TOTAL)) begin
                        r_word  <= r_bad ? '0 : r_mem[r_idx];
                        r_valid <= 1'b1;
                        r_state <= S_VALID;
                        if (r_bad) begin
                            r_err <= 1'b1;
                        end
`ifdef RAM_RESPONDER_STATS_EN
                        r_read_count <= r_read_count + 32'd1;
`endif
                    end else begin
                        r_cnt <= r_cnt + DELAY_CNTR_LEN'(1);
                    end
                end
                S_VALID: begin
                    if (!ram_read) begin
                        r_valid <= 1'b0;
                        r_state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ram_valid = r_valid;
    assign ram_word  = r_word;
    assign busy      = r_busy;
    assign addr_err  = r_err;
`ifdef RAM_RESPONDER_STATS_EN
    assign read_count = r_read_count;
`endif

endmodule

// File: tb/tb_ram_word_responder.sv
// tb/tb_ram_word_responder.sv - randomized bench for ram_word_responder against a transaction-level model
module tb_ram_word_responder;

    logic        clk = 1'b0;
    logic        rst_L;
    logic [31:0] ram_dma_addr;
    logic        ram_read;
    logic        ram_valid;
    logic [15:0] ram_word;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        addr_err;
    logic        err_clr;
`ifdef RAM_RESPONDER_STATS_EN
    logic [31:0] read_count;
`endif

    always #5 clk = ~clk;

    ram_word_responder dut (
        .clk          (clk),
        .rst_L        (rst_L),
        .ram_dma_addr (ram_dma_addr),
        .ram_read     (ram_read),
        .ram_valid    (ram_valid),
        .ram_word     (ram_word),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .addr_err     (addr_err),
        .err_clr      (err_clr)
`ifdef RAM_RESPONDER_STATS_EN
        ,
        .read_count   (read_count)
`endif
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] m_mem [0:4095];
    logic        exp_valid = 1'b0;
    logic        exp_busy  = 1'b0;
    logic        exp_err   = 1'b0;
    logic [15:0] exp_word  = 16'h0;
    bit          word_chk  = 1'b0;
    bit          chk_en    = 1'b0;
    bit          rnd_wr    = 1'b0;
    int unsigned m_count   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ram_valid", {31'b0, ram_valid}, {31'b0, exp_valid});
            check("busy", {31'b0, busy}, {31'b0, exp_busy});
            check("addr_err", {31'b0, addr_err}, {31'b0, exp_err});
            if (exp_valid || word_chk) begin
                check("ram_word", {16'b0, ram_word}, {16'b0, exp_word});
            end
`ifdef RAM_RESPONDER_STATS_EN
            check("read_count", read_count, m_count);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word model: byte offset from start 0, 2-byte stride, 4096 words.
    function automatic bit m_bad(input logic [31:0] addr);
        return (addr % 2 != 0) || (addr / 2 >= 4096);
    endfunction

    function automatic logic [15:0] m_read(input logic [31:0] addr);
        logic [31:0] idx;
        idx = addr / 2;
        return m_bad(addr) ? 16'h0 : m_mem[idx[11:0]];
    endfunction

    task automatic rand_write();
        if (rnd_wr && $urandom_range(0, 3) == 0) begin
            wr_en   = 1'b1;
            wr_addr = 12'($urandom_range(0, 63));
            wr_data = 16'($urandom);
        end
    endtask

    task automatic apply_write();
        if (wr_en) begin
            m_mem[wr_addr] = wr_data;
            wr_en = 1'b0;
        end
    endtask

    task automatic write_word(input logic [11:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        apply_write();
    endtask

    task automatic clr_err();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic do_reset();
        rst_L = 1'b0; ram_read = 1'b0; wr_en = 1'b0; err_clr = 1'b0;
        tick();
        exp_valid = 1'b0; exp_busy = 1'b0; exp_err = 1'b0; exp_word = 16'h0;
        word_chk = 1'b1; m_count = 0;
        rst_L = 1'b1;
    endtask

    // One request: acceptance, 12 waiting edges, valid on the 13th, then release.
    task automatic do_read(input logic [31:0] addr, input int hold, input bit early, input bit rel_read,
                           input bit edge_wr, input logic [11:0] ewa, input logic [15:0] ewd,
                           input bit edge_clr, output logic [15:0] got_word, output logic got_err);
        logic [15:0] w;
        bit          bad;
        bad = m_bad(addr);
        ram_dma_addr = addr; ram_read = 1'b1;
        tick();
        exp_busy = 1'b1; word_chk = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            ram_dma_addr = $urandom;
            if (early && k == 3) ram_read = 1'b0;
            rand_write();
            tick();
            apply_write();
        end
        w = m_read(addr);
        if (edge_wr) begin
            wr_en = 1'b1; wr_addr = ewa; wr_data = ewd;
        end
        err_clr = edge_clr;
        tick();
        apply_write();
        err_clr = 1'b0;
        exp_valid = 1'b1; exp_word = w;
        if (bad) exp_err = 1'b1;
        else if (edge_clr) exp_err = 1'b0;
        m_count++;
        got_word = ram_word; got_err = addr_err;
        if (!early) begin
            repeat (hold) tick();
            ram_read = 1'b0;
        end
        tick();
        exp_valid = 1'b0;
        ram_read = rel_read;
        tick();
        exp_busy = 1'b0;
        ram_read = 1'b0;
    endtask

    task automatic abort_read(input logic [31:0] addr, input bit in_valid);
        ram_dma_addr = addr; ram_read = 1'b1;
        tick();
        exp_busy = 1'b1; word_chk = 1'b0;
        if (in_valid) begin
            repeat (12) tick();
            tick();
            exp_valid = 1'b1; exp_word = m_read(addr);
            if (m_bad(addr)) exp_err = 1'b1;
            m_count++;
            tick();
        end else begin
            repeat (5) tick();
        end
        do_reset();
    endtask

    logic [15:0] gw;
    logic        ge;
    logic [31:0] ra;

    initial begin
        rst_L = 1'b0; ram_read = 1'b0; ram_dma_addr = 32'h0;
        wr_en = 1'b0; wr_addr = 12'h0; wr_data = 16'h0; err_clr = 1'b0;
        do_reset();
        chk_en = 1'b1;
        check("rst_valid", {31'b0, ram_valid}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_err", {31'b0, addr_err}, 32'h0);
        check("rst_word", {16'b0, ram_word}, 32'h0);

        for (int i = 0; i < 64; i++) write_word(12'(i), 16'($urandom));
        write_word(12'd5, 16'hBEEF);
        write_word(12'd7, 16'h2222);

        do_read(32'hA, 3, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0, 1'b0, gw, ge);
        check("t1_word", {16'b0, gw}, 32'h0000BEEF);
        check("t1_err", {31'b0, ge}, 32'h0);

        do_read(32'h3, 1, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0, 1'b0, gw, ge);
        check("t2_word", {16'b0, gw}, 32'h0);
        check("t2_err", {31'b0, ge}, 32'h1);
        clr_err();
        check("t2_clr", {31'b0, addr_err}, 32'h0);

        do_read(32'h2000, 0, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0, 1'b0, gw, ge);
        check("t3_word", {16'b0, gw}, 32'h0);
        check("t3_err", {31'b0, ge}, 32'h1);
        do_read(32'h0, 2, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0, 1'b0, gw, ge);
        clr_err();

        do_read(32'hE, 1, 1'b0, 1'b1, 1'b1, 12'd7, 16'h1111, 1'b0, gw, ge);
        check("t4_old", {16'b0, gw}, 32'h00002222);
        do_read(32'hE, 1, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0, 1'b0, gw, ge);
        check("t4_new", {16'b0, gw}, 32'h00001111);

        do_read(32'h5, 0, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0, 1'b1, gw, ge);
        check("set_wins", {31'b0, ge}, 32'h1);
        clr_err();

        abort_read(32'hA, 1'b0);
        check("t5_wait_valid", {31'b0, ram_valid}, 32'h0);
        check("t5_wait_busy", {31'b0, busy}, 32'h0);
        abort_read(32'hA, 1'b1);
        check("t5_valid_valid", {31'b0, ram_valid}, 32'h0);
        check("t5_valid_busy", {31'b0, busy}, 32'h0);
        do_read(32'hA, 1, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0, 1'b0, gw, ge);
        check("t5_mem_kept", {16'b0, gw}, 32'h0000BEEF);

        do_read(32'hA, 0, 1'b1, 1'b0, 1'b0, 12'h0, 16'h0, 1'b0, gw, ge);
        check("t6_pulse_word", {16'b0, gw}, 32'h0000BEEF);

        abort_read(32'h4, 1'b0);
        for (int i = 0; i < 3; i++)
            do_read(32'h8, 0, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0, 1'b0, gw, ge);
`ifdef RAM_RESPONDER_STATS_EN
        check("t6_count", read_count, 32'd3);
`endif

        rnd_wr = 1'b1;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0, 1:    ra = 32'($urandom_range(0, 63)) << 1;
                2:       ra = (32'($urandom_range(0, 63)) << 1) | 32'h1;
                default: ra = $urandom | 32'h0001_0000;
            endcase
            do_read(ra, $urandom_range(0, 3), ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                    1'b0, 12'h0, 16'h0, ($urandom_range(0, 7) == 0), gw, ge);
            if ($urandom_range(0, 4) == 0) clr_err();
            if ($urandom_range(0, 4) == 0) write_word(12'($urandom_range(0, 63)), 16'($urandom));
        end
        rnd_wr = 1'b0;
        tick();
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
